// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper and its settle timer.
// Vector count and settle-counter width are derived here so the top and timer agree.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  localparam int N_IN_DEFAULT = 4;
  localparam int N_VEC        = 2 ** N_IN_DEFAULT;

  function automatic int n_vec(input int n_in);
    return 1 << n_in;
  endfunction

  // Width needed to hold the settle count; never below one bit.
  function automatic int settle_cnt_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter timing the settle interval; expired is high in the last settle cycle.
// Zero latency from count to expired; load always wins over the decrement.
import tt_sweep_pkg::*;

module tt_settle_timer #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset_b,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks vec through all 2**N_IN values, settles, samples f_in into table_out; done pulses after 2**N_IN*(SETTLE+1)+1 edges.
// No backpressure: start is ignored while busy/done, abort drops the sweep. TT_SWEEP_CHECK_EN adds expected-table comparison.
import tt_sweep_pkg::*;

module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clock,
  input  logic                   reset_b,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   f_in,
  output logic [N_IN-1:0]        vec,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out
`ifdef TT_SWEEP_CHECK_EN
  ,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic                   mismatch,
  output logic [N_IN:0]          err_count
`endif
);

  localparam int              NV   = n_vec(N_IN);
  localparam int              CW   = settle_cnt_w(SETTLE);
  localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);
  // With no settle interval each vector goes straight to sampling.
  localparam tt_state_e       ST_APPLY = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  tt_state_e state;
  logic      tmr_load;
  logic      tmr_expired;

  always_comb begin
    tmr_load = 1'b0;
    if (!abort) begin
      if (state == ST_IDLE && start) begin
        tmr_load = 1'b1;
      end else if (state == ST_SAMPLE && vec != LAST) begin
        tmr_load = 1'b1;
      end
    end
  end

  tt_settle_timer #(.W(CW)) u_settle (
    .clock   (clock),
    .reset_b (reset_b),
    .load    (tmr_load),
    .value   (CW'(SETTLE)),
    .expired (tmr_expired)
  );

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state     <= ST_IDLE;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
`ifdef TT_SWEEP_CHECK_EN
      mismatch  <= 1'b0;
      err_count <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            table_out <= '0;
            vec       <= '0;
            busy      <= 1'b1;
            state     <= ST_APPLY;
`ifdef TT_SWEEP_CHECK_EN
            mismatch  <= 1'b0;
            err_count <= '0;
`endif
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
            vec   <= '0;
            busy  <= 1'b0;
          end else if (tmr_expired) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // Abort beats the table write in the same cycle.
          if (abort) begin
            state <= ST_IDLE;
            vec   <= '0;
            busy  <= 1'b0;
          end else begin
            table_out[vec] <= f_in;
`ifdef TT_SWEEP_CHECK_EN
            if (f_in != expected[vec]) begin
              err_count <= err_count + 1'b1;
              mismatch  <= 1'b1;
            end
`endif
            if (vec == LAST) begin
              state <= ST_DONE;
              vec   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec   <= vec + 1'b1;
              state <= ST_APPLY;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          vec   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          vec   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
